// File: rtl/vending_machine_multi.sv
// Multi-channel vending controller: per-channel price/stock, coin credit,
// vend, change return, cancel refund and COLLECT inactivity timeout.
module vending_machine_multi #(
    parameter int N_PROD      = 4,
    parameter int SEL_W       = 2,
    parameter int CREDIT_W    = 8,
    parameter int STOCK_W     = 4,
    parameter int INIT_STOCK  = 5,
    parameter int INIT_PRICE  = 20,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SEL_W-1:0]    sel,
    input  logic                sel_valid,
    input  logic                rs_10,
    input  logic                rs_20,
    input  logic                cancel,
    input  logic                price_wr,
    input  logic [SEL_W-1:0]    price_idx,
    input  logic [CREDIT_W-1:0] price_data,
    input  logic                restock,
    input  logic [SEL_W-1:0]    restock_idx,
    output logic [N_PROD-1:0]   product,
    output logic [CREDIT_W-1:0] change,
    output logic                change_valid,
    output logic                no_product,
    output logic                coin_reject,
    output logic [2:0]          state,
    output logic [CREDIT_W-1:0] credit
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_VEND    = 3'd2,
        S_CHANGE  = 3'd3,
        S_REFUND  = 3'd4
    } state_t;

    // Headroom bits so a 30-unit coin never wraps before the overflow test
    localparam int SUM_W = CREDIT_W + 6;
    localparam int TMO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

    state_t r_state;
    state_t w_next;

    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] r_price_l;
    logic [SEL_W-1:0]    r_sel;
    logic [CREDIT_W-1:0] r_price [N_PROD];
    logic [STOCK_W-1:0]  r_stock [N_PROD];
    logic [TMO_W-1:0]    r_tmo;
    logic                r_no_product;
    logic                r_coin_reject;

    logic                w_sel_ok;
    logic [CREDIT_W-1:0] w_sel_price;
    logic [SUM_W-1:0]    w_coin_val;
    logic [SUM_W-1:0]    w_sum;
    logic                w_coin_any;
    logic                w_ovf;
    logic                w_coin_ok;
    logic                w_tmo_hit;
    logic [N_PROD-1:0]   w_dec;
    logic [N_PROD-1:0]   w_inc;

    // Out-of-range indices match no channel and are rejected
    always_comb begin
        w_sel_ok    = 1'b0;
        w_sel_price = '0;
        for (int i = 0; i < N_PROD; i++) begin
            if (sel == SEL_W'(i)) begin
                w_sel_ok    = (r_stock[i] != '0);
                w_sel_price = r_price[i];
            end
        end
    end

    assign w_coin_val = (rs_10 ? SUM_W'(10) : '0)
                      + (rs_20 ? SUM_W'(20) : '0);
    assign w_coin_any = rs_10 | rs_20;
    assign w_sum      = SUM_W'(r_credit) + w_coin_val;
    assign w_ovf      = |w_sum[SUM_W-1:CREDIT_W];
    assign w_coin_ok  = (r_state == S_COLLECT) && w_coin_any
                      && !cancel && !w_ovf;

    generate
        if (TIMEOUT_CYC == 0) begin : g_no_tmo
            assign w_tmo_hit = 1'b0;
        end else begin : g_tmo
            assign w_tmo_hit = (r_tmo >= TMO_W'(TIMEOUT_CYC - 1));
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < N_PROD; i++) begin
            w_dec[i] = (r_state == S_VEND) && (r_sel == SEL_W'(i));
            w_inc[i] = restock && (restock_idx == SEL_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        change       = '0;
        change_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (sel_valid && w_sel_ok) begin
                    w_next = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (cancel) begin
                    w_next = (r_credit != '0) ? S_REFUND : S_IDLE;
                end else if (r_credit >= r_price_l) begin
                    w_next = S_VEND;
                end else if (w_tmo_hit && !w_coin_ok) begin
                    w_next = (r_credit != '0) ? S_REFUND : S_IDLE;
                end
            end
            S_VEND: begin
                w_next = (r_credit > r_price_l) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE, S_REFUND: begin
                change_valid = 1'b1;
                change       = r_credit;
                w_next       = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credit      <= '0;
            r_price_l     <= '0;
            r_sel         <= '0;
            r_tmo         <= '0;
            r_no_product  <= 1'b0;
            r_coin_reject <= 1'b0;
        end else begin
            r_no_product  <= (r_state == S_IDLE) && sel_valid
                           && !w_sel_ok;
            r_coin_reject <= w_coin_any && !w_coin_ok;
            unique case (r_state)
                S_IDLE: begin
                    if (sel_valid && w_sel_ok) begin
                        r_sel     <= sel;
                        r_price_l <= w_sel_price;
                        r_tmo     <= TMO_W'(1);
                    end
                end
                S_COLLECT: begin
                    if (w_coin_ok) begin
                        r_credit <= w_sum[CREDIT_W-1:0];
                        r_tmo    <= TMO_W'(1);
                    end else if (r_tmo != {TMO_W{1'b1}}) begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_VEND: begin
                    r_credit <= r_credit - r_price_l;
                end
                S_CHANGE, S_REFUND: begin
                    r_credit <= '0;
                end
                default: begin
                    r_credit <= '0;
                end
            endcase
        end
    end

    // Restock and vend on the same channel cancel out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_PROD; i++) begin
                r_price[i] <= CREDIT_W'(INIT_PRICE);
                r_stock[i] <= STOCK_W'(INIT_STOCK);
            end
        end else begin
            for (int i = 0; i < N_PROD; i++) begin
                if (price_wr && (price_idx == SEL_W'(i))) begin
                    r_price[i] <= price_data;
                end
                if (w_inc[i] && !w_dec[i]) begin
                    if (r_stock[i] != {STOCK_W{1'b1}}) begin
                        r_stock[i] <= r_stock[i] + 1'b1;
                    end
                end else if (w_dec[i] && !w_inc[i]) begin
                    r_stock[i] <= r_stock[i] - 1'b1;
                end
            end
        end
    end

    assign product     = w_dec;
    assign no_product  = r_no_product;
    assign coin_reject = r_coin_reject;
    assign state       = r_state;
    assign credit      = r_credit;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed bench for vending_machine_multi: scoreboard of expected
// product/change pulses plus inline register/state checks.
module tb_vending_machine_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sel;
    logic       sel_valid;
    logic       rs_10;
    logic       rs_20;
    logic       s_rs_10;
    logic       s_rs_20;
    logic       cancel;
    logic       price_wr;
    logic [1:0] price_idx;
    logic [7:0] price_data;
    logic       restock;
    logic [1:0] restock_idx;

    logic [3:0] product;
    logic [7:0] change;
    logic       change_valid;
    logic       no_product;
    logic       coin_reject;
    logic [2:0] state;
    logic [7:0] credit;

    logic [3:0] s_product;
    logic [4:0] s_change;
    logic       s_change_valid;
    logic       s_no_product;
    logic       s_coin_reject;
    logic [2:0] s_state;
    logic [4:0] s_credit;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        int         cyc;
        logic [3:0] prod;
        logic       cv;
        logic [7:0] chg;
    } exp_t;
    exp_t exp_q[$];

    vending_machine_multi #(
        .TIMEOUT_CYC(8)
    ) u_dut (
        .clk(clk), .rst(rst),
        .sel(sel), .sel_valid(sel_valid),
        .rs_10(rs_10), .rs_20(rs_20), .cancel(cancel),
        .price_wr(price_wr), .price_idx(price_idx),
        .price_data(price_data),
        .restock(restock), .restock_idx(restock_idx),
        .product(product), .change(change),
        .change_valid(change_valid), .no_product(no_product),
        .coin_reject(coin_reject), .state(state),
        .credit(credit)
    );

    vending_machine_multi #(
        .CREDIT_W(5),
        .TIMEOUT_CYC(8)
    ) u_small (
        .clk(clk), .rst(rst),
        .sel(sel), .sel_valid(sel_valid),
        .rs_10(s_rs_10), .rs_20(s_rs_20), .cancel(cancel),
        .price_wr(price_wr), .price_idx(price_idx),
        .price_data(price_data[4:0]),
        .restock(restock), .restock_idx(restock_idx),
        .product(s_product), .change(s_change),
        .change_valid(s_change_valid), .no_product(s_no_product),
        .coin_reject(s_coin_reject), .state(s_state),
        .credit(s_credit)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_out(input int c, input logic [3:0] p,
                              input logic cv, input logic [7:0] ch);
        exp_t e;
        e.cyc  = c;
        e.prod = p;
        e.cv   = cv;
        e.chg  = ch;
        exp_q.push_back(e);
    endtask

    task automatic clr();
        sel = '0; sel_valid = 0; rs_10 = 0; rs_20 = 0;
        s_rs_10 = 0; s_rs_20 = 0; cancel = 0;
        price_wr = 0; price_idx = '0; price_data = '0;
        restock = 0; restock_idx = '0;
    endtask

    // Scoreboard side: every product/change pulse must match the head entry
    always @(negedge clk) begin
        if (!rst && (product != '0 || change_valid)) begin
            check("out_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_cycle", 32'(cyc), 32'(e.cyc));
                check("out_product", 32'(product), 32'(e.prod));
                check("out_change_valid", 32'(change_valid), 32'(e.cv));
                check("out_change", 32'(change), 32'(e.chg));
            end
        end
    end

    initial begin
        clr();
        rst = 1;
        step(2);
        check("rst_state", 32'(state), 32'd0);
        check("rst_credit", 32'(credit), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        check("rst_cv", 32'(change_valid), 32'd0);
        check("rst_change", 32'(change), 32'd0);
        check("rst_no_product", 32'(no_product), 32'd0);
        check("rst_coin_reject", 32'(coin_reject), 32'd0);
        check("rst_stock3", 32'(u_dut.r_stock[3]), 32'd5);
        rst = 0;
        step(1);

        // ch0 exact payment with two 10s
        sel = 2'd0; sel_valid = 1; step(1); sel_valid = 0;
        check("t1_collect", 32'(state), 32'd1);
        rs_10 = 1; step(1); rs_10 = 0;
        check("t1_credit10", 32'(credit), 32'd10);
        rs_10 = 1;
        expect_out(cyc + 2, 4'b0001, 1'b0, 8'd0);
        step(1); rs_10 = 0;
        check("t1_credit20", 32'(credit), 32'd20);
        step(1);
        check("t1_vend", 32'(state), 32'd2);
        step(1);
        check("t1_idle", 32'(state), 32'd0);
        check("t1_credit0", 32'(credit), 32'd0);
        check("t1_stock0", 32'(u_dut.r_stock[0]), 32'd4);

        // ch3 at price 30, overpay by 10
        price_wr = 1; price_idx = 2'd3; price_data = 8'd30;
        step(1); price_wr = 0;
        sel = 2'd3; sel_valid = 1; step(1); sel_valid = 0;
        rs_20 = 1; step(1);
        check("t2_credit20", 32'(credit), 32'd20);
        expect_out(cyc + 2, 4'b1000, 1'b0, 8'd0);
        expect_out(cyc + 3, 4'b0000, 1'b1, 8'd10);
        step(1); rs_20 = 0;
        check("t2_credit40", 32'(credit), 32'd40);
        step(1);
        check("t2_vend", 32'(state), 32'd2);
        step(1);
        check("t2_change_state", 32'(state), 32'd3);
        check("t2_credit_rem", 32'(credit), 32'd10);
        step(1);
        check("t2_idle", 32'(state), 32'd0);
        check("t2_credit0", 32'(credit), 32'd0);

        // price write racing a selection keeps the old price (30)
        sel = 2'd3; sel_valid = 1;
        price_wr = 1; price_idx = 2'd3; price_data = 8'd10;
        step(1); sel_valid = 0; price_wr = 0;
        rs_20 = 1; step(1); rs_20 = 0;
        step(1);
        check("t2b_still_collect", 32'(state), 32'd1);
        check("t2b_credit20", 32'(credit), 32'd20);
        rs_10 = 1;
        expect_out(cyc + 2, 4'b1000, 1'b0, 8'd0);
        step(1); rs_10 = 0;
        step(2);
        check("t2b_idle", 32'(state), 32'd0);
        check("t2b_new_price", 32'(u_dut.r_price[3]), 32'd10);

        // cancel with credit -> refund, no product
        sel = 2'd1; sel_valid = 1; step(1); sel_valid = 0;
        rs_10 = 1; step(1); rs_10 = 0;
        cancel = 1;
        expect_out(cyc + 1, 4'b0000, 1'b1, 8'd10);
        step(1); cancel = 0;
        check("t3_refund", 32'(state), 32'd4);
        step(1);
        check("t3_idle", 32'(state), 32'd0);
        check("t3_stock1", 32'(u_dut.r_stock[1]), 32'd5);

        // drain ch2, then reject, then restock
        for (int k = 0; k < 5; k++) begin
            sel = 2'd2; sel_valid = 1; step(1); sel_valid = 0;
            rs_20 = 1;
            expect_out(cyc + 2, 4'b0100, 1'b0, 8'd0);
            step(1); rs_20 = 0;
            step(2);
        end
        check("t4_stock2_empty", 32'(u_dut.r_stock[2]), 32'd0);
        sel = 2'd2; sel_valid = 1; step(1); sel_valid = 0;
        check("t4_no_product", 32'(no_product), 32'd1);
        check("t4_stay_idle", 32'(state), 32'd0);
        step(1);
        check("t4_no_product_pulse", 32'(no_product), 32'd0);
        restock = 1; restock_idx = 2'd2; step(1); restock = 0;
        sel = 2'd2; sel_valid = 1; step(1); sel_valid = 0;
        check("t4_restocked_sel", 32'(state), 32'd1);
        cancel = 1; step(1); cancel = 0;
        check("t4_cancel_zero", 32'(state), 32'd0);
        rs_10 = 1; step(1); rs_10 = 0;
        check("t4_idle_coin_rej", 32'(coin_reject), 32'd1);
        check("t4_idle_credit", 32'(credit), 32'd0);

        // restock coinciding with vend on ch0: stock stays 4
        sel = 2'd0; sel_valid = 1; step(1); sel_valid = 0;
        rs_20 = 1;
        expect_out(cyc + 2, 4'b0001, 1'b0, 8'd0);
        step(1); rs_20 = 0;
        step(1);
        restock = 1; restock_idx = 2'd0; step(1); restock = 0;
        check("t4_vend_restock", 32'(u_dut.r_stock[0]), 32'd4);

        // price 0 vends with no coin
        price_wr = 1; price_idx = 2'd1; price_data = 8'd0;
        step(1); price_wr = 0;
        sel = 2'd1; sel_valid = 1;
        expect_out(cyc + 2, 4'b0010, 1'b0, 8'd0);
        step(1); sel_valid = 0;
        step(2);
        check("t4_free_idle", 32'(state), 32'd0);

        // 5-bit credit overflow rejects the whole coin cycle
        rst = 1; step(1); rst = 0; step(1);
        price_wr = 1; price_idx = 2'd0; price_data = 8'd30;
        step(1); price_wr = 0;
        sel = 2'd0; sel_valid = 1; step(1); sel_valid = 0;
        s_rs_20 = 1; step(1); s_rs_20 = 0;
        check("t5_credit20", 32'(s_credit), 32'd20);
        s_rs_20 = 1; s_rs_10 = 1; step(1);
        s_rs_20 = 0; s_rs_10 = 0;
        check("t5_ovf_reject", 32'(s_coin_reject), 32'd1);
        check("t5_ovf_credit", 32'(s_credit), 32'd20);
        check("t5_ovf_state", 32'(s_state), 32'd1);
        s_rs_10 = 1; step(1); s_rs_10 = 0;
        check("t5_fit_credit", 32'(s_credit), 32'd30);
        check("t5_fit_accept", 32'(s_coin_reject), 32'd0);
        step(1);
        check("t5_fit_vend", 32'(s_product), 32'd1);

        // inactivity timeout refund, then reset mid-COLLECT
        rst = 1; step(1); rst = 0; step(1);
        sel = 2'd0; sel_valid = 1; step(1); sel_valid = 0;
        rs_10 = 1;
        expect_out(cyc + 8, 4'b0000, 1'b1, 8'd10);
        step(1); rs_10 = 0;
        step(6);
        check("t6_pre_timeout", 32'(state), 32'd1);
        step(1);
        check("t6_timeout_refund", 32'(state), 32'd4);
        step(1);
        check("t6_idle", 32'(state), 32'd0);
        sel = 2'd0; sel_valid = 1; step(1); sel_valid = 0;
        rs_20 = 1; step(1); rs_20 = 0;
        check("t6_credit20", 32'(credit), 32'd20);
        rst = 1; #1;
        check("t6_rst_credit", 32'(credit), 32'd0);
        check("t6_rst_state", 32'(state), 32'd0);
        check("t6_rst_cv", 32'(change_valid), 32'd0);
        step(2); rst = 0;
        step(3);
        check("t6_post_rst_state", 32'(state), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vending_machine_multi.md
Name: vending_machine_multi

Overview:
- Parametrised successor to the single-shot vending controller.
- Supports N_PROD product channels with programmable per-channel prices and per-channel stock counters.
- Accumulates coin credit, vends once credit covers the latched price, then returns change in a dedicated cycle.
- Supports cancel/refund and an inactivity timeout; sits between the coin/keypad front end and the dispenser actuators.

Parameters:
- N_PROD, 4, number of product channels (2..16).
- SEL_W, 2, selection index width; must satisfy 2**SEL_W >= N_PROD.
- CREDIT_W, 8, width of credit, price and change values (currency units).
- STOCK_W, 4, per-channel stock counter width.
- INIT_STOCK, 5, stock loaded into every channel at reset.
- INIT_PRICE, 20, price loaded into every channel at reset.
- TIMEOUT_CYC, 255, COLLECT-state inactivity cycles before auto-refund; 0 disables the timeout.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- sel, input, SEL_W, product index; sampled when sel_valid=1.
- sel_valid, input, 1, selection strobe.
- rs_10, input, 1, 10-unit coin inserted this cycle.
- rs_20, input, 1, 20-unit coin inserted this cycle.
- cancel, input, 1, customer cancel request.
- price_wr, input, 1, price write strobe.
- price_idx, input, SEL_W, channel whose price is written.
- price_data, input, CREDIT_W, new price value.
- restock, input, 1, add one unit to channel restock_idx.
- restock_idx, input, SEL_W, channel to restock.
- product, output, N_PROD, one-hot dispense pulse, one cycle.
- change, output, CREDIT_W, change/refund amount; valid only when change_valid=1.
- change_valid, output, 1, one-cycle change/refund strobe.
- no_product, output, 1, one-cycle pulse: selection rejected (stock 0 or index >= N_PROD).
- coin_reject, output, 1, one-cycle pulse: coin rejected (not in COLLECT, or credit would overflow).
- state, output, 3, current FSM state encoding.
- credit, output, CREDIT_W, current accumulated credit.

Behaviour:
- Reset (async):
  - state=IDLE (0); credit=0.
  - All pulse outputs 0; change=0.
  - Every stock counter = INIT_STOCK; every price = INIT_PRICE.
- States: IDLE=0, COLLECT=1, VEND=2, CHANGE=3, REFUND=4.
- IDLE:
  - sel_valid with a valid index and stock>0 latches sel and that channel's price, then moves to COLLECT next cycle.
  - Otherwise no_product pulses and the FSM stays in IDLE.
  - Coins in IDLE pulse coin_reject; credit is unchanged.
  - sel_valid outside IDLE is ignored.
- COLLECT:
  - Coin value = 10*rs_10 + 20*rs_20; both asserted adds 30.
  - If credit+value exceeds 2**CREDIT_W-1, the whole cycle's coins are rejected (coin_reject) and credit is unchanged.
  - Credit updates one cycle after the coin.
  - Transition to VEND in the cycle after credit >= latched price.
  - cancel or timeout: go to REFUND if credit>0, else IDLE.
  - Precedence in the same cycle: cancel > coin.
  - Timeout counter resets on entry and on each accepted coin; expiry after TIMEOUT_CYC cycles with no accepted coin.
- VEND (1 cycle):
  - product[sel_l] pulses; stock[sel_l] decrements; credit <= credit - price_l.
  - Next state is CHANGE if the remainder >0, else IDLE.
  - cancel and coins are ignored; coins pulse coin_reject.
- CHANGE / REFUND (1 cycle each):
  - change_valid=1 and change=credit; credit cleared to 0; next state IDLE.
- price_wr:
  - Updates the price array in any state.
  - A transaction in progress keeps its latched price.
  - A write in the same cycle as a selection latches the old price.
- restock:
  - Increments stock, saturating at 2**STOCK_W-1.
  - If it coincides with the VEND decrement on the same channel, the net stock change is 0.
- Price 0 selection: COLLECT is entered, then VEND follows next cycle with no coin required.
- Reset mid-transaction discards credit with no refund pulse.
- Latency from the coin that completes the price to the product pulse: 2 cycles.

Test Plan:
- Reset, select ch0 (price 20), rs_10 twice -> credit 10 then 20; product=0001 exactly 2 cycles after the second coin; no change_valid; stock[0]=4.
- Program price[3]=30, select ch3, rs_20 twice -> product=1000, then change_valid with change=10 next cycle, credit=0, state=IDLE.
- Select ch1, rs_10 once, cancel -> REFUND: change_valid, change=10; no product pulse; stock[1] unchanged=5.
- Select ch2 five times with exact payment to drain stock, sixth selection -> no_product pulse, state stays 0; one restock on ch2 -> next selection accepted.
- CREDIT_W=5, price 30: insert rs_20 then rs_20 concurrently with rs_10 -> second coin cycle rejected (20+30>31), coin_reject=1, credit stays 20.
- TIMEOUT_CYC=8: select, rs_10, then idle -> change_valid with change=10 exactly 8 cycles after the last accepted coin; also assert rst mid-COLLECT -> outputs and credit 0 immediately, no change_valid.
